// File: rtl/irq_ctrl8_pkg.sv
// irq_pkg: shared constants and FSM state encoding for the irq_ctrl8 block.
//   NUM_IRQ  number of interrupt request lines
//   ID_W     width of an encoded line index
//   state_e  controller FSM states
package irq_pkg;

    localparam int NUM_IRQ = 8;
    localparam int ID_W    = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/irq_ctrl8_if.sv
// irq_ctrl8_if: request/acknowledge bus between the interrupt controller and
// its consumer.
//   enable, req, mask_we, mask_in, irq_ack, eoi : driven by the consumer side
//   irq, irq_id, in_service, pending            : driven by the controller
// Modports: master = consumer side, slave = controller side.
interface irq_ctrl8_if;
    import irq_pkg::*;

    logic                enable;
    logic [NUM_IRQ-1:0]  req;
    logic                mask_we;
    logic [NUM_IRQ-1:0]  mask_in;
    logic                irq_ack;
    logic                eoi;
    logic                irq;
    logic [ID_W-1:0]     irq_id;
    logic                in_service;
    logic [NUM_IRQ-1:0]  pending;

    modport master (
        output enable, req, mask_we, mask_in, irq_ack, eoi,
        input  irq, irq_id, in_service, pending
    );

    modport slave (
        input  enable, req, mask_we, mask_in, irq_ack, eoi,
        output irq, irq_id, in_service, pending
    );

endinterface

// File: rtl/irq_ctrl8_prio_enc8.sv
// irq_prio_enc8: combinational 8-to-3 priority encoder, bit 7 highest.
//   vec_i  candidate vector
//   idx_o  index of the highest set bit (0 when none set)
//   vld_o  at least one bit of vec_i is set
module irq_prio_enc8
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] vec_i,
    output logic [ID_W-1:0]    idx_o,
    output logic               vld_o
);

    // Ascending scan: the last set bit seen (the highest) wins.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (vec_i[i]) begin
                idx_o = ID_W'(i);
            end
        end
    end

    assign vld_o = |vec_i;

endmodule

// File: rtl/irq_ctrl8.sv
// irq_ctrl8: 8-line prioritised interrupt controller.
// Rising edges on req lines set pending bits; the highest unmasked pending
// line is presented on irq/irq_id, accepted with irq_ack and retired with eoi.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    irq_ctrl8_if.slave (enable, req, mask_we, mask_in, irq_ack, eoi
//          in; irq, irq_id, in_service, pending out)
module irq_ctrl8
    import irq_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    irq_ctrl8_if.slave     bus
);

    state_e              state_q;
    logic [NUM_IRQ-1:0]  req_d_q;
    logic [NUM_IRQ-1:0]  mask_q;
    logic [NUM_IRQ-1:0]  pending_q;
    logic [NUM_IRQ-1:0]  pending_d;
    logic [NUM_IRQ-1:0]  rise;
    logic [NUM_IRQ-1:0]  cand;
    logic [ID_W-1:0]     sel_id;
    logic                sel_vld;
    logic                irq_q;
    logic                in_service_q;
    logic [ID_W-1:0]     irq_id_q;
    logic                ack_take;

    assign rise     = bus.req & ~req_d_q;
    assign cand     = pending_q & ~mask_q;
    assign ack_take = (state_q == ASSERT) && bus.irq_ack;

    irq_prio_enc8 u_enc (
        .vec_i (cand),
        .idx_o (sel_id),
        .vld_o (sel_vld)
    );

    // Clear of the accepted line is applied first so that a coincident new
    // rising edge on the same line re-sets it.
    always_comb begin
        pending_d = pending_q;
        if (ack_take) begin
            pending_d[irq_id_q] = 1'b0;
        end
        pending_d = pending_d | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d_q   <= '0;
            mask_q    <= '0;
            pending_q <= '0;
        end else begin
            req_d_q   <= bus.req;
            pending_q <= pending_d;
            if (bus.mask_we) begin
                mask_q <= bus.mask_in;
            end
        end
    end

    // Presentation FSM with registered outputs; irq_id is only loaded on
    // the IDLE->ASSERT edge, which freezes it through ASSERT and SERVICE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            irq_q        <= 1'b0;
            in_service_q <= 1'b0;
            irq_id_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.enable && sel_vld) begin
                        state_q  <= ASSERT;
                        irq_q    <= 1'b1;
                        irq_id_q <= sel_id;
                    end
                end
                ASSERT: begin
                    // Ack takes precedence over a simultaneous enable drop.
                    if (bus.irq_ack) begin
                        state_q      <= SERVICE;
                        irq_q        <= 1'b0;
                        in_service_q <= 1'b1;
                    end else if (!bus.enable) begin
                        state_q <= IDLE;
                        irq_q   <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (bus.eoi) begin
                        state_q      <= IDLE;
                        in_service_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    irq_q        <= 1'b0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq        = irq_q;
    assign bus.irq_id     = irq_id_q;
    assign bus.in_service = in_service_q;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_irq_ctrl8.sv
// Testbench for irq_ctrl8: directed scenarios plus randomized traffic, all
// compared against a behavioural model of the controller's rules.
module tb_irq_ctrl8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    irq_ctrl8_if bus ();

    irq_ctrl8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode 0 = nothing shown, 1 = presenting, 2 = servicing.
    typedef struct packed {
        logic [7:0] pend;
        logic [7:0] mask;
        logic [7:0] prev;
        logic [1:0] mode;
        logic [2:0] id;
    } mstate_t;

    mstate_t m;

    function automatic int highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic en,
                                           input logic [7:0] rq, input logic mwe,
                                           input logic [7:0] min, input logic ack,
                                           input logic e);
        mstate_t n;
        int h;
        n = s;
        h = highest(s.pend & ~s.mask);
        if (s.mode == 2'd0) begin
            if (en && h >= 0) begin
                n.mode = 2'd1;
                n.id   = 3'(h);
            end
        end else if (s.mode == 2'd1) begin
            if (ack) begin
                n.mode = 2'd2;
                n.pend[s.id] = 1'b0;
            end else if (!en) begin
                n.mode = 2'd0;
            end
        end else begin
            if (e) n.mode = 2'd0;
        end
        n.pend = n.pend | (rq & ~s.prev);
        n.prev = rq;
        if (mwe) n.mask = min;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= model_next(m, bus.enable, bus.req, bus.mask_we, bus.mask_in,
                             bus.irq_ack, bus.eoi);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.enable = 1'b1; bus.req = 8'h00; bus.mask_we = 1'b0;
        bus.mask_in = 8'h00; bus.irq_ack = 1'b0; bus.eoi = 1'b0;
        #1;
        checks++;
        if ({bus.irq, bus.in_service, bus.irq_id, bus.pending} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state: got irq=%b ins=%b id=%0d pend=%h required all zero",
                     bus.irq, bus.in_service, bus.irq_id, bus.pending);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.req = 8'h04;
        tick();
        checks++;
        if (bus.pending !== 8'h04 || bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL single_pending: got pend=%h irq=%b required 04/0", bus.pending, bus.irq);
        end
        tick();
        checks++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 3'd2) begin
            errors++;
            $display("FAIL single_present: got irq=%b id=%0d required 1/2", bus.irq, bus.irq_id);
        end
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        checks++;
        if (bus.pending !== 8'h00 || bus.in_service !== 1'b1 || bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: got pend=%h ins=%b irq=%b required 00/1/0",
                     bus.pending, bus.in_service, bus.irq);
        end
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.irq !== 1'b0 || bus.in_service !== 1'b0) begin
                errors++;
                $display("FAIL single_no_retrigger: got irq=%b ins=%b required 0/0",
                         bus.irq, bus.in_service);
            end
            tick();
        end
        bus.req = 8'h00; tick();
    endtask

    task automatic test_priority();
        logic [2:0] exp_ids [3];
        exp_ids[0] = 3'd7; exp_ids[1] = 3'd5; exp_ids[2] = 3'd2;
        bus.req = 8'hA4;
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.irq !== 1'b1 || bus.irq_id !== exp_ids[k]) begin
                errors++;
                $display("FAIL priority_id%0d: got irq=%b id=%0d required 1/%0d",
                         k, bus.irq, bus.irq_id, exp_ids[k]);
            end
            bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
            bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
            checks++;
            if (bus.irq !== 1'b0) begin
                errors++;
                $display("FAIL priority_idle_gap: got irq=%b required 0", bus.irq);
            end
            tick();
        end
        checks++;
        if (bus.pending !== 8'h00) begin
            errors++;
            $display("FAIL priority_drain: got pend=%h required 00", bus.pending);
        end
        bus.req = 8'h00; tick();
    endtask

    task automatic test_mask_enable();
        bus.mask_we = 1'b1; bus.mask_in = 8'h80; tick(); bus.mask_we = 1'b0;
        bus.req = 8'h88; tick(); tick();
        checks++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 3'd3) begin
            errors++;
            $display("FAIL mask_select: got irq=%b id=%0d required 1/3", bus.irq, bus.irq_id);
        end
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
        bus.req = 8'h00; tick();
        bus.enable = 1'b0; bus.req = 8'h01;
        tick(); tick(); tick();
        checks++;
        if (bus.irq !== 1'b0 || bus.pending !== 8'h81) begin
            errors++;
            $display("FAIL enable_off: got irq=%b pend=%h required 0/81", bus.irq, bus.pending);
        end
        bus.enable = 1'b1; tick();
        checks++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 3'd0) begin
            errors++;
            $display("FAIL enable_on: got irq=%b id=%0d required 1/0", bus.irq, bus.irq_id);
        end
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
        bus.req = 8'h00;
        bus.mask_we = 1'b1; bus.mask_in = 8'h00; tick(); bus.mask_we = 1'b0;
        tick();
        checks++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 3'd7) begin
            errors++;
            $display("FAIL unmask_present: got irq=%b id=%0d required 1/7", bus.irq, bus.irq_id);
        end
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    endtask

    task automatic test_freeze_collision();
        bus.req = 8'h02; tick(); tick();
        bus.req = 8'h42; tick();
        checks++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 3'd1 || bus.pending !== 8'h42) begin
            errors++;
            $display("FAIL freeze_id: got irq=%b id=%0d pend=%h required 1/1/42",
                     bus.irq, bus.irq_id, bus.pending);
        end
        bus.req = 8'h40; tick();
        bus.req = 8'h42; bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        checks++;
        if (bus.pending !== 8'h42 || bus.in_service !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: got pend=%h ins=%b required 42/1", bus.pending, bus.in_service);
        end
        for (int i = 0; i < 20; i++) begin
            if (bus.pending === 8'h00 && !bus.irq && !bus.in_service) break;
            if (bus.irq) bus.irq_ack = 1'b1;
            else if (bus.in_service) bus.eoi = 1'b1;
            tick();
            bus.irq_ack = 1'b0; bus.eoi = 1'b0;
        end
        checks++;
        if (bus.pending !== 8'h00 || bus.irq !== 1'b0 || bus.in_service !== 1'b0) begin
            errors++;
            $display("FAIL freeze_drain: got pend=%h irq=%b ins=%b required 00/0/0 within 20 cycles",
                     bus.pending, bus.irq, bus.in_service);
        end
        bus.req = 8'h00; tick();
    endtask

    task automatic test_reset_mid();
        bus.req = 8'h01; tick(); tick();
        bus.req = 8'h31; bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        checks++;
        if (bus.pending !== 8'h30 || bus.in_service !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: got pend=%h ins=%b required 30/1", bus.pending, bus.in_service);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.irq, bus.in_service, bus.irq_id, bus.pending} !== 13'd0) begin
            errors++;
            $display("FAIL rst_async: got irq=%b ins=%b id=%0d pend=%h required all zero",
                     bus.irq, bus.in_service, bus.irq_id, bus.pending);
        end
        bus.req = 8'h10;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 3'd4 || bus.pending !== 8'h10) begin
            errors++;
            $display("FAIL rst_release: got irq=%b id=%0d pend=%h required 1/4/10",
                     bus.irq, bus.irq_id, bus.pending);
        end
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
        bus.req = 8'h00; tick();
    endtask

    task automatic test_random();
        logic [12:0] exp;
        for (int c = 0; c < 1500; c++) begin
            bus.enable  = ($urandom_range(0, 7) != 0);
            bus.req     = 8'($urandom);
            bus.mask_we = ($urandom_range(0, 15) == 0);
            bus.mask_in = 8'($urandom) & 8'($urandom);
            bus.irq_ack = $urandom_range(0, 1) == 1;
            bus.eoi     = $urandom_range(0, 1) == 1;
            tick();
            exp = {m.mode == 2'd1, m.mode == 2'd2, m.id, m.pend};
            checks++;
            if ({bus.irq, bus.in_service, bus.irq_id, bus.pending} !== exp ||
                (bus.irq && bus.in_service)) begin
                errors++;
                $display("FAIL random_c%0d: got irq=%b ins=%b id=%0d pend=%h required irq=%b ins=%b id=%0d pend=%h",
                         c, bus.irq, bus.in_service, bus.irq_id, bus.pending,
                         exp[12], exp[11], exp[10:8], exp[7:0]);
            end
        end
        bus.irq_ack = 1'b0; bus.eoi = 1'b0; bus.mask_we = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_priority();
        test_mask_enable();
        test_freeze_collision();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
